// File: rtl/fc_output_stage_pkg.sv
// Shared fixed-point definitions for the LSTM datapath: word geometry, FC stage
// states and sign-magnitude <-> two's complement conversion helpers.
package lstm_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned FRAC_BITS  = 16;
  localparam int unsigned UNITS      = 4;
  localparam logic [DATA_WIDTH-1:0] ONE_FX = DATA_WIDTH'(1) << FRAC_BITS;

  // Product magnitude after the fractional shift, and a worst-case accumulator
  // wide enough for UNITS products plus the bias without wrapping.
  localparam int unsigned PROD_W = 2 * (DATA_WIDTH - 1) - FRAC_BITS;
  localparam int unsigned ACC_W  = 2 * DATA_WIDTH - 1 - FRAC_BITS + $clog2(UNITS + 1) + 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    $signed({{(ACC_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX;

  typedef enum logic [1:0] {IDLE, MAC, BIAS, OUT} fc_state_t;

  typedef struct packed {
    logic                  ovf;
    logic [DATA_WIDTH-1:0] word;
  } sm_sat_t;

  function automatic logic signed [ACC_W-1:0] sm_to_tc(input logic sign,
                                                        input logic [ACC_W-2:0] mag);
    logic signed [ACC_W-1:0] v;
    v = $signed({1'b0, mag});
    return sign ? -v : v;
  endfunction

  // Negative results are never zero here, so -0 cannot be produced.
  function automatic sm_sat_t tc_to_sm_sat(input logic signed [ACC_W-1:0] acc);
    sm_sat_t r;
    r = '0;
    if (acc > SAT_MAX) begin
      r.ovf  = 1'b1;
      r.word = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    end else if (acc < SAT_MIN) begin
      r.ovf  = 1'b1;
      r.word = '1;
    end else if (acc[ACC_W-1]) begin
      r.word = {1'b1, (DATA_WIDTH - 1)'(-acc)};
    end else begin
      r.word = {1'b0, (DATA_WIDTH - 1)'(acc)};
    end
    return r;
  endfunction

endpackage

// File: rtl/fc_output_stage_if.sv
// Valid/ready bundle between the LSTM hidden-vector producer, the FC output
// stage and the prediction consumer.
interface fc_output_stage_if
  import lstm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = lstm_pkg::DATA_WIDTH,
  parameter int unsigned UNITS      = lstm_pkg::UNITS
);
  logic                        in_valid;
  logic                        in_ready;
  logic [UNITS*DATA_WIDTH-1:0] ht_in;
  logic [UNITS*DATA_WIDTH-1:0] w_fc;
  logic [DATA_WIDTH-1:0]       b_fc;
  logic                        pred_valid;
  logic                        pred_ready;
  logic [DATA_WIDTH-1:0]       pred;
  logic                        pred_ovf;

  modport master (
    output in_valid, ht_in, w_fc, b_fc, pred_ready,
    input  in_ready, pred_valid, pred, pred_ovf
  );

  modport slave (
    input  in_valid, ht_in, w_fc, b_fc, pred_ready,
    output in_ready, pred_valid, pred, pred_ovf
  );
endinterface

// File: rtl/fc_output_stage_sm_mult.sv
// Combinational sign-magnitude fixed-point multiplier; magnitude truncates toward
// zero and a zero magnitude always carries a positive sign.
module sm_mult #(
  parameter int unsigned DATA_WIDTH = lstm_pkg::DATA_WIDTH,
  parameter int unsigned FRAC_BITS  = lstm_pkg::FRAC_BITS
) (
  input  logic [DATA_WIDTH-1:0]                   i_a,
  input  logic [DATA_WIDTH-1:0]                   i_b,
  output logic                                    o_sign,
  output logic [2*(DATA_WIDTH-1)-FRAC_BITS-1:0]   o_mag
);
  localparam int unsigned FULL_W = 2 * (DATA_WIDTH - 1);
  localparam int unsigned MAG_W  = FULL_W - FRAC_BITS;

  logic [FULL_W-1:0] w_full;

  assign w_full = FULL_W'(i_a[DATA_WIDTH-2:0]) * FULL_W'(i_b[DATA_WIDTH-2:0]);
  assign o_mag  = MAG_W'(w_full >> FRAC_BITS);
  assign o_sign = (i_a[DATA_WIDTH-1] ^ i_b[DATA_WIDTH-1]) && (o_mag != '0);
endmodule

// File: rtl/fc_output_stage.sv
// Sequential dense output layer: pred = sum(ht[i]*w[i]) + b using one shared
// sign-magnitude multiplier, with saturating output and valid/ready on both sides.
module fc_output_stage
  import lstm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = lstm_pkg::DATA_WIDTH,
  parameter int unsigned FRAC_BITS  = lstm_pkg::FRAC_BITS,
  parameter int unsigned UNITS      = lstm_pkg::UNITS
) (
  input  logic              clk,
  input  logic              rst,
  fc_output_stage_if.slave  fc
);
  localparam int unsigned PW = 2 * (DATA_WIDTH - 1) - FRAC_BITS;
  localparam int unsigned IW = (UNITS > 1) ? $clog2(UNITS) : 1;

  fc_state_t                   r_state;
  logic [IW-1:0]               r_idx;
  logic [UNITS*DATA_WIDTH-1:0] r_ht;
  logic [UNITS*DATA_WIDTH-1:0] r_w;
  logic [DATA_WIDTH-1:0]       r_b;
  logic signed [ACC_W-1:0]     r_acc;
  logic [DATA_WIDTH-1:0]       r_pred;
  logic                        r_pred_ovf;
  logic                        r_pred_valid;

  logic                        w_sign;
  logic [PW-1:0]               w_mag;
  logic signed [ACC_W-1:0]     w_prod_tc;
  logic signed [ACC_W-1:0]     w_bias_tc;
  logic signed [ACC_W-1:0]     w_sum;
  sm_sat_t                     w_sat;

  sm_mult #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_mult (
    .i_a    (r_ht[r_idx*DATA_WIDTH +: DATA_WIDTH]),
    .i_b    (r_w[r_idx*DATA_WIDTH +: DATA_WIDTH]),
    .o_sign (w_sign),
    .o_mag  (w_mag)
  );

  assign w_prod_tc = sm_to_tc(w_sign, (ACC_W - 1)'(w_mag));
  assign w_bias_tc = sm_to_tc(r_b[DATA_WIDTH-1], (ACC_W - 1)'(r_b[DATA_WIDTH-2:0]));
  assign w_sum     = r_acc + w_bias_tc;
  assign w_sat     = tc_to_sm_sat(w_sum);

  assign fc.in_ready   = (r_state == IDLE) && !rst;
  assign fc.pred_valid = r_pred_valid;
  assign fc.pred       = r_pred;
  assign fc.pred_ovf   = r_pred_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_ht         <= '0;
      r_w          <= '0;
      r_b          <= '0;
      r_acc        <= '0;
      r_pred       <= '0;
      r_pred_ovf   <= 1'b0;
      r_pred_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (fc.in_valid) begin
          r_ht    <= fc.ht_in;
          r_w     <= fc.w_fc;
          r_b     <= fc.b_fc;
          r_acc   <= '0;
          r_idx   <= '0;
          r_state <= MAC;
        end
        MAC: begin
          r_acc <= r_acc + w_prod_tc;
          if (r_idx == IW'(UNITS - 1)) r_state <= BIAS;
          else                         r_idx   <= r_idx + 1'b1;
        end
        BIAS: begin
          r_acc        <= w_sum;
          r_pred       <= w_sat.word;
          r_pred_ovf   <= w_sat.ovf;
          r_pred_valid <= 1'b1;
          r_state      <= OUT;
        end
        OUT: if (fc.pred_ready) begin
          r_pred_valid <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
